// File: rtl/sseg_scan_pkg.sv
// Shared constants for the seven-segment scan decoder: glyph patterns
// (active-low a..g, bit6=a), FSM state encoding and digit count.
package sseg_scan_pkg;

  localparam int NDIG = 4;

  localparam logic [6:0] SSEG_GLYPH_0 = 7'b0000001;
  localparam logic [6:0] SSEG_GLYPH_1 = 7'b1001111;
  localparam logic [6:0] SSEG_GLYPH_2 = 7'b0010010;
  localparam logic [6:0] SSEG_GLYPH_3 = 7'b0000110;
  localparam logic [6:0] SSEG_GLYPH_4 = 7'b1001100;
  localparam logic [6:0] SSEG_GLYPH_5 = 7'b0100100;
  localparam logic [6:0] SSEG_GLYPH_6 = 7'b0100000;
  localparam logic [6:0] SSEG_GLYPH_7 = 7'b0001111;
  localparam logic [6:0] SSEG_GLYPH_8 = 7'b0000000;
  localparam logic [6:0] SSEG_GLYPH_9 = 7'b0000100;
  localparam logic [6:0] SSEG_GLYPH_A = 7'b0001000;
  localparam logic [6:0] SSEG_GLYPH_B = 7'b1100000;
  localparam logic [6:0] SSEG_GLYPH_C = 7'b0110001;
  localparam logic [6:0] SSEG_GLYPH_D = 7'b1000010;
  localparam logic [6:0] SSEG_GLYPH_E = 7'b0110000;
  localparam logic [6:0] SSEG_GLYPH_F = 7'b0111000;
  localparam logic [6:0] SSEG_BLANK   = 7'b1111111;

  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sseg_scan_decoder_glyph.sv
// Combinational seven-segment glyph decoder: maps an active-low a..g pattern
// back to its hex nibble; legal is low (nibble 0) for any non-glyph pattern.
module sseg_glyph_decode
  import sseg_scan_pkg::*;
(
  input  logic [6:0] sseg,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    case (sseg)
      SSEG_GLYPH_0: nibble = 4'h0;
      SSEG_GLYPH_1: nibble = 4'h1;
      SSEG_GLYPH_2: nibble = 4'h2;
      SSEG_GLYPH_3: nibble = 4'h3;
      SSEG_GLYPH_4: nibble = 4'h4;
      SSEG_GLYPH_5: nibble = 4'h5;
      SSEG_GLYPH_6: nibble = 4'h6;
      SSEG_GLYPH_7: nibble = 4'h7;
      SSEG_GLYPH_8: nibble = 4'h8;
      SSEG_GLYPH_9: nibble = 4'h9;
      SSEG_GLYPH_A: nibble = 4'hA;
      SSEG_GLYPH_B: nibble = 4'hB;
      SSEG_GLYPH_C: nibble = 4'hC;
      SSEG_GLYPH_D: nibble = 4'hD;
      SSEG_GLYPH_E: nibble = 4'hE;
      SSEG_GLYPH_F: nibble = 4'hF;
      default:      legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus: settles,
// decodes and assembles frames. Optional stall watchdog under SSEG_STALL_DET_EN.
module sseg_scan_decoder
  import sseg_scan_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int STALL_W    = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  output logic [15:0] digits,
  output logic [3:0]  digit_ok,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        err,
  output logic        stall
);

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYC - 1);

  logic [3:0]  an_meta, an_sync, an_cmp;
  logic [6:0]  sseg_meta, sseg_sync, sseg_cmp;
  logic [7:0]  count, count_next;
  logic [3:0]  seen;
  logic [15:0] prev_frame;
  logic        capture, same;
  logic [1:0]  sel;
  logic        one_low;
  logic [3:0]  nibble;
  logic        legal;

  scan_state_t state, next_state;

  // Synchronisers and compare stage reset to the idle bus (all lines high)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_meta   <= '1;
      an_sync   <= '1;
      an_cmp    <= '1;
      sseg_meta <= '1;
      sseg_sync <= '1;
      sseg_cmp  <= '1;
    end else begin
      an_meta   <= an;
      an_sync   <= an_meta;
      an_cmp    <= an_sync;
      sseg_meta <= sseg;
      sseg_sync <= sseg_meta;
      sseg_cmp  <= sseg_sync;
    end
  end

  assign same = ({an_sync, sseg_sync} == {an_cmp, sseg_cmp});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SETTLE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= count_next;
    end
  end

  always_comb begin
    next_state = state;
    count_next = count;
    capture    = 1'b0;
    case (state)
      SETTLE: begin
        if (!same) begin
          count_next = '0;
        end else if (count == LAST_CNT) begin
          capture    = 1'b1;
          next_state = HOLD;
        end else begin
          count_next = count + 8'd1;
        end
      end
      HOLD: begin
        if (!same) begin
          count_next = '0;
          next_state = SETTLE;
        end
      end
      default: next_state = SETTLE;
    endcase
  end

  always_comb begin
    sel     = 2'd0;
    one_low = 1'b0;
    case (an_cmp)
      4'b1110: begin sel = 2'd0; one_low = 1'b1; end
      4'b1101: begin sel = 2'd1; one_low = 1'b1; end
      4'b1011: begin sel = 2'd2; one_low = 1'b1; end
      4'b0111: begin sel = 2'd3; one_low = 1'b1; end
      default: ;
    endcase
  end

  sseg_glyph_decode u_glyph (
    .sseg   (sseg_cmp),
    .nibble (nibble),
    .legal  (legal)
  );

  // A completed frame is reported the cycle after its last slot was written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits        <= '0;
      digit_ok      <= '0;
      seen          <= '0;
      prev_frame    <= '0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      err           <= 1'b0;
    end else begin
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      err           <= 1'b0;
      if (seen == 4'b1111) begin
        frame_valid   <= 1'b1;
        frame_changed <= (digits != prev_frame);
        prev_frame    <= digits;
        seen          <= '0;
      end
      if (capture) begin
        if (one_low) begin
          digits[{sel, 2'b00} +: 4] <= legal ? nibble : 4'h0;
          digit_ok[sel]             <= legal;
          seen[sel]                 <= 1'b1;
        end else if (an_cmp != 4'b1111) begin
          err <= 1'b1;
        end
      end
    end
  end

`ifdef SSEG_STALL_DET_EN
  logic [STALL_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (frame_valid) begin
      stall_cnt <= '0;
    end else if (stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall = (stall_cnt == '1);
`else
  // Watchdog absent: the width parameter only keeps the interface identical
  assign stall = (STALL_W < 0);
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Self-checking bench for sseg_scan_decoder: run-length reference model checked
// every cycle plus directed checks. Define SSEG_STALL_DET_EN to cover the watchdog.
module tb_sseg_scan_decoder;

  localparam int S = 4;
`ifdef SSEG_STALL_DET_EN
  localparam int SW = 6;
`else
  localparam int SW = 20;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  sseg = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  digit_ok;
  logic        frame_valid, frame_changed, err, stall;

  int total = 0;
  int bad = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  logic last_fc = 1'b0;

  logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  always #5 clk = ~clk;

  sseg_scan_decoder #(.STABLE_CYC(S), .STALL_W(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .an            (an),
    .sseg          (sseg),
    .digits        (digits),
    .digit_ok      (digit_ok),
    .frame_valid   (frame_valid),
    .frame_changed (frame_changed),
    .err           (err),
    .stall         (stall)
  );

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bus value is captured once it has been seen for S+1
  // consecutive samples, observed two cycles late through the synchroniser.
  logic [10:0] d1, d2, last, v;
  int          run_len, zeros, idx, stall_cnt;
  logic [15:0] m_digits, m_prev;
  logic [3:0]  m_ok, m_seen, nib;
  logic        m_fv, m_fc, m_err, m_stall, gok;

  function automatic void decode(input logic [6:0] s, output logic [3:0] n, output logic ok);
    n = 4'h0;
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (glyph[k] == s) begin
        n = 4'(k);
        ok = 1'b1;
      end
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1 = '1; d2 = '1; last = '1; run_len = 1;
      m_digits = '0; m_prev = '0; m_ok = '0; m_seen = '0;
      m_fv = 0; m_fc = 0; m_err = 0; stall_cnt = 0;
    end else begin
      if (m_fv) stall_cnt = 0;
      else if (stall_cnt < (2 ** SW) - 1) stall_cnt++;
      m_fv = 0; m_fc = 0; m_err = 0;
      if (m_seen == 4'hF) begin
        m_fv = 1;
        m_fc = (m_digits != m_prev);
        m_prev = m_digits;
        m_seen = '0;
      end
      v = d2; d2 = d1; d1 = {an, sseg};
      if (v == last) run_len++;
      else begin last = v; run_len = 1; end
      if (run_len == S + 1) begin
        zeros = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (!v[7+i]) begin zeros++; idx = i; end
        if (zeros == 1) begin
          decode(v[6:0], nib, gok);
          m_digits[idx*4 +: 4] = nib;
          m_ok[idx] = gok;
          m_seen[idx] = 1'b1;
        end else if (zeros > 1) begin
          m_err = 1;
        end
      end
    end
`ifdef SSEG_STALL_DET_EN
    m_stall = (stall_cnt == (2 ** SW) - 1);
`else
    m_stall = 1'b0;
`endif
  end

  // Every-cycle comparison against the model, plus pulse bookkeeping
  always @(negedge clk) begin
    check_output("digits", digits, m_digits);
    check_output("digit_ok", {12'b0, digit_ok}, {12'b0, m_ok});
    check_output("frame_valid", {15'b0, frame_valid}, {15'b0, m_fv});
    check_output("frame_changed", {15'b0, frame_changed}, {15'b0, m_fc});
    check_output("err", {15'b0, err}, {15'b0, m_err});
    check_output("stall", {15'b0, stall}, {15'b0, m_stall});
    if (frame_valid === 1'b1) begin fv_cnt++; last_fc = frame_changed; end
    if (err === 1'b1) err_cnt++;
  end

  task automatic apply_stimulus(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a;
    sseg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [15:0] frame);
    for (int i = 0; i < 4; i++) apply_stimulus(~(4'b0001 << i), glyph[frame[i*4 +: 4]], 10);
  endtask

  int f0, e0;
  logic [15:0] saved;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_digits", digits, 16'h0000);
    check_output("reset_pulses", {13'b0, frame_valid, frame_changed, err}, 16'h0);
    reset = 1'b1;
    apply_stimulus(4'hF, 7'h7F, 8);

    $display("[TB] settling latency");
    an = 4'b1110; sseg = 7'b0010010;
    repeat (6) @(posedge clk);
    #1;
    check_output("latency_before", {12'b0, digits[3:0]}, 16'h0000);
    @(posedge clk);
    #1;
    check_output("latency_at", {12'b0, digits[3:0]}, 16'h0002);
    check_output("latency_ok0", {15'b0, digit_ok[0]}, 16'h0001);
    apply_stimulus(4'b1110, 7'b0010010, 13);
    check_output("latency_no_frame", 16'(fv_cnt), 16'd0);

    $display("[TB] first frame, repeat, scroll");
    scan(16'h0123);
    check_output("frame1_count", 16'(fv_cnt), 16'd1);
    check_output("frame1_digits", digits, 16'h0123);
    check_output("frame1_changed", {15'b0, last_fc}, 16'h0001);
    scan(16'h0123);
    check_output("repeat_count", 16'(fv_cnt), 16'd2);
    check_output("repeat_changed", {15'b0, last_fc}, 16'h0000);
    scan(16'h1234);
    check_output("scroll_digits", digits, 16'h1234);
    check_output("scroll_changed", {15'b0, last_fc}, 16'h0001);

    $display("[TB] glitch and illegal inputs");
    apply_stimulus(4'b1110, glyph[5], 10);
    apply_stimulus(4'b1101, glyph[8], S - 1);
    apply_stimulus(4'b1101, glyph[6], 4);
    check_output("glitch_no_capture", {12'b0, digits[7:4]}, 16'h0003);
    apply_stimulus(4'b1101, glyph[6], 6);
    check_output("glitch_then_capture", {12'b0, digits[7:4]}, 16'h0006);
    saved = digits;
    e0 = err_cnt;
    apply_stimulus(4'b1100, glyph[1], 12);
    check_output("multi_anode_err", 16'(err_cnt - e0), 16'd1);
    check_output("multi_anode_digits", digits, saved);
    apply_stimulus(4'b1011, 7'b1111111, 10);
    check_output("blank_glyph_ok2", {15'b0, digit_ok[2]}, 16'h0000);
    check_output("blank_glyph_nib", {12'b0, digits[11:8]}, 16'h0000);
    f0 = fv_cnt;
    apply_stimulus(4'b0111, glyph[9], 10);
    check_output("after_err_frame", 16'(fv_cnt - f0), 16'd1);
    check_output("after_err_digits", digits, 16'h9065);

    $display("[TB] reset mid-frame");
    apply_stimulus(4'b1110, glyph[7], 10);
    apply_stimulus(4'b1101, glyph[10], 10);
    reset = 1'b0;
    #1;
    check_output("midreset_digits", digits, 16'h0000);
    check_output("midreset_ok", {12'b0, digit_ok}, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    f0 = fv_cnt;
    apply_stimulus(4'b1110, glyph[11], 10);
    apply_stimulus(4'b1101, glyph[12], 10);
    apply_stimulus(4'b1011, glyph[13], 10);
    check_output("reset_needs_four", 16'(fv_cnt - f0), 16'd0);
    apply_stimulus(4'b0111, glyph[14], 10);
    check_output("reset_frame_count", 16'(fv_cnt - f0), 16'd1);
    check_output("reset_frame_digits", digits, 16'hEDCB);
    check_output("reset_frame_changed", {15'b0, last_fc}, 16'h0001);

`ifdef SSEG_STALL_DET_EN
    $display("[TB] stall watchdog");
    apply_stimulus(4'hF, 7'h7F, 70);
    check_output("stall_set", {15'b0, stall}, 16'h0001);
    scan(16'h4321);
    check_output("stall_cleared", {15'b0, stall}, 16'h0000);
`else
    apply_stimulus(4'hF, 7'h7F, 20);
    check_output("stall_tied_low", {15'b0, stall}, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
